exp_fsmd_param: RTL and testbench

Parametrised successor to the fixed-width exponent FSMD. Computes `result = a^n` for `W`-bit unsigned operands into an `RW`-bit result. Two run-time modes: linear repeated multiply, and square-and-multiply. Adds busy/done handshaking and sticky overflow detection. The block sits between the input switches and the LCD/7-segment display path: `done_o` starts the LCD controller, and `result_o` drives the hex displays.

---
 rtl/exp_pkg.sv | 15 +
 rtl/exp_mul.sv | 19 +
 rtl/exp_fsmd_param.sv | 120 ++++++++++++
 tb/tb_exp_fsmd_param.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared types and constants for the parametrised exponent FSMD.
package exp_pkg;

  // Control states of the exponent FSMD.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } exp_state_t;

  // Run-time algorithm selection carried on mode_i.
  localparam logic MODE_LIN = 1'b0;  // repeated multiply, n+1 RUN cycles
  localparam logic MODE_SQR = 1'b1;  // square-and-multiply, bitlen(n)+1 RUN cycles

endpackage

// File: rtl/exp_mul.sv
// Unsigned RW x RW -> 2RW multiplier, split into high and low halves.
// The high half is what the controller inspects for overflow.
module exp_mul #(
  parameter int RW = 16
) (
  input  logic [RW-1:0] x,
  input  logic [RW-1:0] y,
  output logic [RW-1:0] hi,
  output logic [RW-1:0] lo
);

  logic [2*RW-1:0] prod;

  // Both operands widened first so the full double-width product is kept.
  assign prod = {{RW{1'b0}}, x} * {{RW{1'b0}}, y};
  assign hi   = prod[2*RW-1:RW];
  assign lo   = prod[RW-1:0];

endmodule

// File: rtl/exp_fsmd_param.sv
// Parametrised exponent FSMD: result_o = a_i ** n_i (mod 2^RW) with a sticky
// overflow flag. mode_i picks linear repeated multiply or square-and-multiply.
// Optional build macro: EXP_OVF_SAT_EN -- when defined, an overflowed result
// saturates to all ones instead of wrapping; ovf_o is the same in both builds.
module exp_fsmd_param
  import exp_pkg::*;
#(
  parameter int W  = 8,
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  n_i,
  input  logic          mode_i,
  output logic [RW-1:0] result_o,
  output logic          done_o,
  output logic          busy_o,
  output logic          ovf_o
);

  exp_state_t    state;
  logic [RW-1:0] acc;       // running product
  logic [RW-1:0] base;      // a, or a^(2^i) in square mode
  logic [W-1:0]  n_reg;     // remaining exponent
  logic          mode_reg;  // mode captured at start
  logic          ovf_acc;   // sticky: result multiply overflowed
  logic          bov;       // sticky: base square overflowed (harmless until consumed)

  logic [RW-1:0] prod_hi, prod_lo;
  logic [RW-1:0] sq_hi, sq_lo;

  // Result multiply: acc * base.
  exp_mul #(.RW(RW)) u_mul_res (
    .x  (acc),
    .y  (base),
    .hi (prod_hi),
    .lo (prod_lo)
  );

  // Base square: base * base.
  exp_mul #(.RW(RW)) u_mul_sq (
    .x  (base),
    .y  (base),
    .hi (sq_hi),
    .lo (sq_lo)
  );

  // Control FSM, datapath registers and registered outputs in one process.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every datapath register is cleared here too, so a reset mid-RUN
      // leaves no stale operand or sticky flag behind for the next operation.
      state    <= IDLE;
      acc      <= '0;
      base     <= '0;
      n_reg    <= '0;
      mode_reg <= MODE_LIN;
      ovf_acc  <= 1'b0;
      bov      <= 1'b0;
      result_o <= '0;
      done_o   <= 1'b0;
      busy_o   <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every branch below reads
      // the pre-edge register values, which is what the two multipliers see.
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (go_i) begin
            acc      <= RW'(1);
            base     <= RW'(a_i);
            n_reg    <= n_i;
            mode_reg <= mode_i;
            ovf_acc  <= 1'b0;
            bov      <= 1'b0;
            busy_o   <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          if (n_reg == '0) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else if (mode_reg == MODE_SQR) begin
            // A base that has overflowed only matters once it is multiplied in.
            if (n_reg[0]) begin
              acc <= prod_lo;
              if ((prod_hi != '0) || bov) ovf_acc <= 1'b1;
            end
            base <= sq_lo;
            if (sq_hi != '0) bov <= 1'b1;
            n_reg <= n_reg >> 1;
          end else begin
            acc   <= prod_lo;
            n_reg <= n_reg - W'(1);
            if (prod_hi != '0) ovf_acc <= 1'b1;
          end
        end

        DONE: begin
`ifdef EXP_OVF_SAT_EN
          result_o <= ovf_acc ? {RW{1'b1}} : acc;
`else
          result_o <= acc;
`endif
          ovf_o  <= ovf_acc;
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_fsmd_param.sv
// Directed self-checking bench for exp_fsmd_param (W=8, RW=16).
// Cycle numbering: the cycle after the accepting edge k is cycle k+1, so a
// latency of L means done_o was seen in cycle k+L.
module tb_exp_fsmd_param;

  localparam int W  = 8;
  localparam int RW = 16;

`ifdef EXP_OVF_SAT_EN
  localparam logic [RW-1:0] EXP_2_16  = 16'hFFFF;
  localparam logic [RW-1:0] EXP_3_255 = 16'hFFFF;
`else
  localparam logic [RW-1:0] EXP_2_16  = 16'h0000;
  localparam logic [RW-1:0] EXP_3_255 = 16'hA6AB;  // 3^255 mod 2^16
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          go_i;
  logic [W-1:0]  a_i;
  logic [W-1:0]  n_i;
  logic          mode_i;
  logic [RW-1:0] result_o;
  logic          done_o;
  logic          busy_o;
  logic          ovf_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exp_fsmd_param #(.W(W), .RW(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .go_i     (go_i),
    .a_i      (a_i),
    .n_i      (n_i),
    .mode_i   (mode_i),
    .result_o (result_o),
    .done_o   (done_o),
    .busy_o   (busy_o),
    .ovf_o    (ovf_o)
  );

  // Called just after the accepting edge (+#1); counts cycles until done_o.
  task automatic wait_done(output int lat, output int busy_err,
                           output logic [RW-1:0] res_at_done);
    lat = -1; busy_err = 0; res_at_done = '0;
    for (int c = 1; c <= 400; c++) begin
      if (busy_o !== 1'b1) busy_err++;
      if (done_o === 1'b1) begin
        lat = c;
        res_at_done = result_o;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Starts one operation, waits for done_o, returns the values after DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] n, input logic m,
                        output int lat, output logic [RW-1:0] res, output logic ovf,
                        output int busy_err, output logic [RW-1:0] res_at_done);
    @(negedge clk);
    a_i = a; n_i = n; mode_i = m; go_i = 1'b1;
    @(posedge clk); #1;
    go_i = 1'b0;
    wait_done(lat, busy_err, res_at_done);
    @(posedge clk); #1;
    res = result_o;
    ovf = ovf_o;
    if (busy_o !== 1'b0 || done_o !== 1'b0) busy_err++;
  endtask

  task automatic test_reset();
    rst = 1'b1; go_i = 1'b0; a_i = '0; n_i = '0; mode_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (result_o !== 16'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 0000", result_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    vectors++; if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_linear();
    int lat, be; logic [RW-1:0] res, rad; logic ovf;
    run_op(8'd3, 8'd4, 1'b0, lat, res, ovf, be, rad);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL lin_latency: got %0d expected 6", lat); end
    vectors++; if (res !== 16'h0051) begin miscompares++; $display("FAIL lin_result: got %h expected 0051", res); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL lin_ovf: got %b expected 0", ovf); end
    vectors++; if (be !== 0) begin miscompares++; $display("FAIL lin_busy: got %0d bad cycles expected 0", be); end
    vectors++; if (rad !== 16'h0000) begin miscompares++; $display("FAIL lin_result_held: got %h expected 0000 during DONE", rad); end
  endtask

  task automatic test_square();
    int lat, be; logic [RW-1:0] res, rad; logic ovf;
    run_op(8'd3, 8'd4, 1'b1, lat, res, ovf, be, rad);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL sqr_latency: got %0d expected 5", lat); end
    vectors++; if (res !== 16'h0051) begin miscompares++; $display("FAIL sqr_result: got %h expected 0051", res); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sqr_ovf: got %b expected 0", ovf); end
    vectors++; if (be !== 0) begin miscompares++; $display("FAIL sqr_busy: got %0d bad cycles expected 0", be); end
  endtask

  task automatic test_zero_exp();
    int lat, be; logic [RW-1:0] res, rad; logic ovf;
    logic [W-1:0] av [2];
    av[0] = 8'd0; av[1] = 8'd5;
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        run_op(av[i], 8'd0, m[0], lat, res, ovf, be, rad);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL zero_latency a=%0d m=%0d: got %0d expected 2", av[i], m, lat); end
        vectors++; if (res !== 16'h0001) begin miscompares++; $display("FAIL zero_result a=%0d m=%0d: got %h expected 0001", av[i], m, res); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL zero_ovf a=%0d m=%0d: got %b expected 0", av[i], m, ovf); end
      end
    end
  endtask

  task automatic test_overflow();
    int lat, be; logic [RW-1:0] res, rad; logic ovf;
    for (int m = 0; m < 2; m++) begin
      run_op(8'd2, 8'd16, m[0], lat, res, ovf, be, rad);
      vectors++; if (lat !== ((m == 1) ? 7 : 18)) begin miscompares++; $display("FAIL ovf_latency m=%0d: got %0d", m, lat); end
      vectors++; if (res !== EXP_2_16) begin miscompares++; $display("FAIL ovf_result m=%0d: got %h expected %h", m, res, EXP_2_16); end
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag m=%0d: got %b expected 1", m, ovf); end
      run_op(8'd255, 8'd2, m[0], lat, res, ovf, be, rad);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL max_latency m=%0d: got %0d expected 4", m, lat); end
      vectors++; if (res !== 16'hFE01) begin miscompares++; $display("FAIL max_result m=%0d: got %h expected fe01", m, res); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL max_ovf m=%0d: got %b expected 0", m, ovf); end
    end
  endtask

  task automatic test_mode_equiv();
    int lat_l, lat_s, be; logic [RW-1:0] res_l, res_s, rad; logic ovf_l, ovf_s;
    run_op(8'd3, 8'd255, 1'b0, lat_l, res_l, ovf_l, be, rad);
    run_op(8'd3, 8'd255, 1'b1, lat_s, res_s, ovf_s, be, rad);
    vectors++; if (lat_l !== 257) begin miscompares++; $display("FAIL equiv_lin_latency: got %0d expected 257", lat_l); end
    vectors++; if (lat_s !== 10) begin miscompares++; $display("FAIL equiv_sqr_latency: got %0d expected 10", lat_s); end
    vectors++; if (res_l !== EXP_3_255) begin miscompares++; $display("FAIL equiv_lin_result: got %h expected %h", res_l, EXP_3_255); end
    vectors++; if (res_s !== EXP_3_255) begin miscompares++; $display("FAIL equiv_sqr_result: got %h expected %h", res_s, EXP_3_255); end
    vectors++; if (ovf_l !== 1'b1 || ovf_s !== 1'b1) begin miscompares++; $display("FAIL equiv_ovf: got %b/%b expected 1/1", ovf_l, ovf_s); end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0, busys = 0;
    @(negedge clk);
    a_i = 8'd3; n_i = 8'd255; mode_i = 1'b0; go_i = 1'b1;
    @(posedge clk); #1;
    go_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    vectors++; if (result_o !== 16'h0) begin miscompares++; $display("FAIL midrst_result: got %h expected 0000", result_o); end
    vectors++; if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL midrst_ovf: got %b expected 0", ovf_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) dones++;
      if (busy_o === 1'b1) busys++;
    end
    vectors++; if (dones !== 0 || busys !== 0) begin miscompares++; $display("FAIL midrst_quiet: got %0d done / %0d busy cycles expected 0/0", dones, busys); end
  endtask

  task automatic test_go_held();
    int lat, be, dones = 0; logic [RW-1:0] rad;
    @(negedge clk);
    a_i = 8'd3; n_i = 8'd4; mode_i = 1'b0; go_i = 1'b1;
    @(posedge clk); #1;
    a_i = 8'd7; n_i = 8'd9; mode_i = 1'b1;  // go_i stays high through RUN
    wait_done(lat, be, rad);
    @(negedge clk);
    go_i = 1'b0;
    @(posedge clk); #1;
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL held_latency: got %0d expected 6", lat); end
    vectors++; if (result_o !== 16'h0051) begin miscompares++; $display("FAIL held_result: got %h expected 0051", result_o); end
    for (int c = 0; c < 20; c++) begin
      if (done_o === 1'b1 || busy_o === 1'b1) dones++;
      @(posedge clk); #1;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL held_single_op: got %0d extra active cycles expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    int lat, be; logic [RW-1:0] rad;
    @(negedge clk);
    a_i = 8'd5; n_i = 8'd2; mode_i = 1'b0; go_i = 1'b1;
    @(posedge clk); #1;
    go_i = 1'b0;
    wait_done(lat, be, rad);
    @(negedge clk);  // still in DONE: request the next operation now
    a_i = 8'd2; n_i = 8'd3; mode_i = 1'b1; go_i = 1'b1;
    @(posedge clk); #1;
    vectors++; if (result_o !== 16'd25 || busy_o !== 1'b0) begin miscompares++; $display("FAIL b2b_first: got %h busy %b expected 0019 busy 0", result_o, busy_o); end
    @(posedge clk); #1;
    go_i = 1'b0;
    wait_done(lat, be, rad);
    @(posedge clk); #1;
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    vectors++; if (result_o !== 16'd8) begin miscompares++; $display("FAIL b2b_second: got %h expected 0008", result_o); end
    vectors++; if (be !== 0) begin miscompares++; $display("FAIL b2b_busy: got %0d bad cycles expected 0", be); end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_square();
    test_zero_exp();
    test_overflow();
    test_mode_equiv();
    test_reset_mid_run();
    test_go_held();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
